// File: rtl/demux_n_pkg.sv
// Shared encodings for the demux_n router: command modes and controller states.
package demux_n_pkg;

    localparam logic [1:0] DMX_HOLD  = 2'b00;
    localparam logic [1:0] DMX_PULSE = 2'b01;
    localparam logic [1:0] DMX_SCAN  = 2'b10;
    localparam logic [1:0] DMX_BCAST = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } dmx_state_t;

endpackage

// File: rtl/demux_n_onehot_dec.sv
// Combinational SEL_W-to-2**SEL_W one-hot decoder.
module onehot_dec #(
    parameter int SEL_W = 4
) (
    input  logic [SEL_W-1:0]      i_sel,
    output logic [(2**SEL_W)-1:0] o_onehot
);

    generate
        for (genvar gi = 0; gi < 2**SEL_W; gi++) begin : g_bit
            assign o_onehot[gi] = (i_sel == SEL_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/demux_n.sv
// Registered one-hot router with HOLD, PULSE, BROADCAST and auto-increment SCAN modes.
module demux_n
    import demux_n_pkg::*;
#(
    parameter int SEL_W  = 4,
    parameter int DATA_W = 8,
    localparam int N     = 2**SEL_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [SEL_W-1:0]  mux_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [N-1:0]      out_sel,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              busy,
    output logic              done
);

    dmx_state_t        r_state;
    logic [SEL_W-1:0]  r_idx;
    logic [N-1:0]      r_sel;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;
    logic              r_sticky;

    dmx_state_t        w_state_next;
    logic [SEL_W-1:0]  w_idx_next;
    logic [N-1:0]      w_sel_next;
    logic [DATA_W-1:0] w_data_next;
    logic              w_busy_next;
    logic              w_done_next;
    logic              w_sticky_next;

    logic [SEL_W-1:0]  w_idx_inc;
    logic [SEL_W-1:0]  w_dec_in;
    logic [N-1:0]      w_onehot;

    localparam logic [SEL_W-1:0] LAST_IDX = {SEL_W{1'b1}};

    assign w_idx_inc = r_idx + SEL_W'(1);
    // The single decoder serves both the command select and the next scan step.
    assign w_dec_in  = (r_state == ST_SCAN) ? w_idx_inc : mux_in;

    onehot_dec #(.SEL_W(SEL_W)) u_dec (
        .i_sel    (w_dec_in),
        .o_onehot (w_onehot)
    );

    always_comb begin
        w_state_next  = r_state;
        w_idx_next    = r_idx;
        w_sel_next    = r_sel;
        w_data_next   = r_data;
        w_busy_next   = r_busy;
        w_done_next   = 1'b0;
        w_sticky_next = r_sticky;

        if (r_state == ST_SCAN) begin
            w_idx_next = w_idx_inc;
            w_sel_next = w_onehot;
            if (w_idx_inc == LAST_IDX) begin
                w_done_next  = 1'b1;
                w_busy_next  = 1'b0;
                w_state_next = ST_IDLE;
            end
        end else if (enable) begin
            w_data_next = data_in;
            case (mode)
                DMX_HOLD: begin
                    w_sel_next    = w_onehot;
                    w_sticky_next = 1'b1;
                end
                DMX_PULSE: begin
                    w_sel_next    = w_onehot;
                    w_sticky_next = 1'b0;
                end
                DMX_BCAST: begin
                    w_sel_next    = '1;
                    w_sticky_next = 1'b0;
                end
                default: begin
                    w_idx_next    = mux_in;
                    w_sel_next    = w_onehot;
                    w_sticky_next = 1'b0;
                    // A scan starting on the last index is a single finishing step.
                    if (mux_in == LAST_IDX) begin
                        w_done_next = 1'b1;
                        w_busy_next = 1'b0;
                    end else begin
                        w_busy_next  = 1'b1;
                        w_state_next = ST_SCAN;
                    end
                end
            endcase
        end else if (!r_sticky) begin
            w_sel_next = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_sel    <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sticky <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_idx    <= w_idx_next;
            r_sel    <= w_sel_next;
            r_data   <= w_data_next;
            r_valid  <= |w_sel_next;
            r_busy   <= w_busy_next;
            r_done   <= w_done_next;
            r_sticky <= w_sticky_next;
        end
    end

    assign out_sel   = r_sel;
    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_demux_n.sv
// Scoreboard bench for demux_n: driver pushes model expectations, monitor pops and compares.
module tb_demux_n;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [1:0]  mode;
    logic [3:0]  mux_in;
    logic [7:0]  data_in;
    logic [15:0] out_sel;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        busy;
    logic        done;

    demux_n #(.SEL_W(4), .DATA_W(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .mode      (mode),
        .mux_in    (mux_in),
        .data_in   (data_in),
        .out_sel   (out_sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] sel;
        logic [7:0]  data;
        logic        valid;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t q[$];
    exp_t plan[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_txn    = 0;

    // Reference model: last command's outputs plus a precomputed list of scan steps.
    logic [15:0] m_sel;
    logic [7:0]  m_data;
    bit          m_sticky;

    task automatic model_reset();
        m_sel    = '0;
        m_data   = '0;
        m_sticky = 0;
        plan.delete();
    endtask

    task automatic step(input bit en, input logic [1:0] md, input logic [3:0] sel,
                        input logic [7:0] dat, input string tag);
        exp_t e;
        @(negedge clock);
        enable  = en;
        mode    = md;
        mux_in  = sel;
        data_in = dat;
        e.busy = 0;
        e.done = 0;
        if (plan.size() > 0) begin
            e = plan.pop_front();
            m_sel = e.sel;
        end else if (en) begin
            m_data = dat;
            if (md == 2'd0) begin
                m_sel = 16'(1) << sel;
                m_sticky = 1;
            end else if (md == 2'd1) begin
                m_sel = 16'(1) << sel;
                m_sticky = 0;
            end else if (md == 2'd3) begin
                m_sel = 16'hFFFF;
                m_sticky = 0;
            end else begin
                m_sticky = 0;
                for (int i = int'(sel); i < 16; i++) begin
                    exp_t s;
                    s.sel   = 16'(1) << i;
                    s.busy  = (i < 15);
                    s.done  = (i == 15);
                    s.data  = '0;
                    s.valid = 1;
                    plan.push_back(s);
                end
                e = plan.pop_front();
                m_sel = e.sel;
            end
        end else if (!m_sticky) begin
            m_sel = '0;
        end
        e.sel   = m_sel;
        e.data  = m_data;
        e.valid = (m_sel != 0);
        q.push_back(e);
        $display("txn %0d %s en=%0b mode=%0d mux=%h data=%h -> sel=%h busy=%0b done=%0b",
                 n_txn, tag, en, md, sel, dat, e.sel, e.busy, e.done);
        n_txn++;
    endtask

    always @(posedge clock) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_checks++;
            if (out_sel !== e.sel || out_data !== e.data || out_valid !== e.valid ||
                busy !== e.busy || done !== e.done) begin
                n_fail++;
                $display("FAIL outputs t=%0t got sel=%h data=%h v=%0b busy=%0b done=%0b exp sel=%h data=%h v=%0b busy=%0b done=%0b",
                         $time, out_sel, out_data, out_valid, busy, done,
                         e.sel, e.data, e.valid, e.busy, e.done);
            end
        end
    end

    task automatic check_now(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_now({tag, "_sel"},   out_sel, 16'h0000);
        check_now({tag, "_data"},  16'(out_data), 16'h0000);
        check_now({tag, "_valid"}, 16'(out_valid), 16'h0000);
        check_now({tag, "_busy"},  16'(busy), 16'h0000);
        check_now({tag, "_done"},  16'(done), 16'h0000);
    endtask

    initial begin
        reset = 1'b1; enable = 0; mode = 0; mux_in = 0; data_in = 0;
        model_reset();
        #3;
        check_reset_state("reset");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // HOLD persists through idle cycles
        step(1, 2'd0, 4'h5, 8'hA5, "hold");
        for (int i = 0; i < 10; i++) step(0, $urandom_range(0, 3), 4'($urandom), 8'($urandom), "idle");
        // PULSE back-to-back then idle
        step(1, 2'd1, 4'h3, 8'h11, "pulse");
        step(1, 2'd1, 4'hC, 8'h22, "pulse");
        step(0, 2'd1, 4'h0, 8'h00, "idle");
        // SCAN from C with garbage inputs
        step(1, 2'd2, 4'hC, 8'h33, "scan");
        for (int i = 0; i < 3; i++) step(1, 2'($urandom), 4'($urandom), 8'($urandom), "garbage");
        step(0, 2'd0, 4'h0, 8'h00, "idle");
        // SCAN from F and BROADCAST
        step(1, 2'd2, 4'hF, 8'h44, "scan");
        step(0, 2'd0, 4'h0, 8'h00, "idle");
        step(1, 2'd3, 4'h9, 8'h55, "bcast");
        step(0, 2'd3, 4'h0, 8'h00, "idle");

        // SCAN from 0, reset between edges once index 7 is shown
        step(1, 2'd2, 4'h0, 8'h66, "scan");
        for (int i = 0; i < 7; i++) step(1, 2'($urandom), 4'($urandom), 8'($urandom), "garbage");
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("midscan");
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        step(1, 2'd0, 4'h0, 8'h77, "hold");
        step(0, 2'd2, 4'h8, 8'h00, "idle");

        // randomized commands
        for (int i = 0; i < 500; i++)
            step(($urandom_range(0, 9) < 6), 2'($urandom), 4'($urandom), 8'($urandom), "rand");
        for (int i = 0; i < 20; i++) step(0, 2'($urandom), 4'($urandom), 8'($urandom), "drain");

        @(negedge clock);
        check_now("queue_drained", 16'(q.size()), 16'h0000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
